board_input_port: RTL and testbench
===================================

// Module: board_input_port
// PURPOSE
// - Input-side peripheral for the board top level: synchronises and debounces raw KEY/SW pins.
// - Presents key/switch levels and sticky key-press events to the rv_cpu_top core.
// - Uses a registered memory-mapped read/write slave with an interrupt line.
// - Complements the existing CPU->LEDR output path; sits between the board pins and the CPU bus.
// PARAMETERS
// - DATA_WIDTH       32       bus data width; must be >= N_SW and >= N_KEYS
// - ADDR_WIDTH       32       bus address width; only addr[3:2] decoded
// - N_KEYS           4        number of push-buttons; raw pins are active-low
// - N_SW             10       number of slide switches; raw pins are active-high
// - DEBOUNCE_CYCLES  500000   input must be stable this many clk cycles before acceptance (10 ms @ 50 MHz); >= 2
// PORTS
// - clk      in   1           system clock (CLOCK_50)
// - rst      in   1           synchronous, active-low reset
// - key_raw  in   N_KEYS      raw KEY pins, asynchronous, 0 = pressed
// - sw_raw   in   N_SW        raw SW pins, asynchronous, 1 = on
// - addr     in   ADDR_WIDTH  register address; addr[3:2] selects the register
// - rd_en    in   1           read strobe, 1 cycle
// - wr_en    in   1           write strobe, 1 cycle; ignored if rd_en is high in the same cycle
// - wr_data  in   DATA_WIDTH  write data
// - rd_data  out  DATA_WIDTH  registered read data
// - rd_valid out  1           high for exactly 1 cycle, 1 clk after rd_en
// - irq      out  1           level interrupt = |(EVENTS & IRQ_EN), registered
// BEHAVIOUR
// - Reset (rst==0 at posedge)
//   - rd_data=0, rd_valid=0, irq=0; EVENTS=0, IRQ_EN=0.
//   - Debounced key state = released; debounced switch state = 0; all debounce counters = 0.
// - Synchroniser
//   - 2-flop synchroniser per input bit; key inputs inverted after sync (internal 1 = pressed).
// - Debounce, per bit
//   - sync==stable: counter <= 0.
//   - Otherwise counter increments.
//   - When counter==DEBOUNCE_CYCLES-1: stable <= sync and counter <= 0.
//   - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
//   - Counter width = $clog2(DEBOUNCE_CYCLES).
// - Press event
//   - Key stable 0->1 sets EVENTS[i] in the same cycle stable updates.
//   - Key release sets nothing.
//   - A key held through reset produces one event, DEBOUNCE_CYCLES+2 cycles after reset release.
// - Register map (addr[3:2]); unused upper bits read 0
//   - 0 KEYS    RO: debounced key levels [N_KEYS-1:0]
//   - 1 SW      RO: debounced switch levels [N_SW-1:0]
//   - 2 EVENTS  read-to-clear; write-1-to-clear
//   - 3 IRQ_EN  RW, [N_KEYS-1:0]
// - Read timing: rd_en at cycle T -> rd_data/rd_valid valid at T+1; rd_data holds until the next read.
// - EVENTS read-clear: clears only the bits returned.
// - Simultaneous new event and clear on the same bit: the set wins; the bit stays 1 and is not lost.
// - Back-to-back reads every cycle are supported; there are no wait states.
// - irq updates 1 cycle after EVENTS/IRQ_EN change.
// - Reset mid-debounce discards the partial count; reset mid-read suppresses rd_valid.
// STRUCTURE
// - Shared package/header: register offsets (REG_KEYS=0, REG_SW=1, REG_EVENTS=2, REG_IRQ_EN=3).
// - Sub-module input_debounce (1 bit)
//   - Contains the synchroniser, counter and stable register.
//   - Parameters: DEBOUNCE_CYCLES, ACTIVE_LOW.
//   - Outputs: stable, rise (1-cycle pulse).
//   - Instantiated N_KEYS+N_SW times via generate.
// TESTING (DEBOUNCE_CYCLES=4 in simulation)
// - Reset, then read regs 0..3 -> all 0, rd_valid 1 cycle after each rd_en, irq=0.
// - key_raw[1] 1->0 held 10 cycles -> KEYS=0x2 after 2+4 cycles; EVENTS=0x2; second EVENTS read=0.
// - key_raw[0] low for 3 cycles then high -> KEYS stays 0, EVENTS stays 0 (glitch rejected).
// - IRQ_EN=0x1, press key0 -> irq=1; write EVENTS=0x1 -> irq=0 next cycle.
// - Read EVENTS in the same cycle key2 event fires -> returned bit2 may be 0, but the next read returns 0x4.
// - sw_raw=0x3FF -> SW=0x3FF after 6 cycles; rst=0 mid-count -> SW=0, counters restart.

Source files
------------

// File: rtl/board_input_port_pkg.sv
// rtl/board_input_port_pkg.sv - register map shared by the board input port
package board_input_port_pkg;

    typedef enum logic [1:0] {
        REG_KEYS   = 2'd0,
        REG_SW     = 2'd1,
        REG_EVENTS = 2'd2,
        REG_IRQ_EN = 2'd3
    } reg_sel_e;

    localparam int REG_SEL_LSB = 2;

endpackage

// File: rtl/board_input_port_if.sv
// rtl/board_input_port_if.sv - register bus and interrupt between CPU and board input port
interface board_input_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  irq;

    modport master (
        output addr, rd_en, wr_en, wr_data,
        input  rd_data, rd_valid, irq
    );

    modport slave (
        input  addr, rd_en, wr_en, wr_data,
        output rd_data, rd_valid, irq
    );
endinterface

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - one-bit synchroniser, debounce counter and rising-edge pulse
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          r_meta;
    logic          r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_level;
    logic          w_done;

    assign w_level = ACTIVE_LOW ? ~r_sync : r_sync;
    assign w_done  = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Sync flops reset to the idle pin level so a held input is seen as a fresh change
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta   <= ACTIVE_LOW;
            r_sync   <= ACTIVE_LOW;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (w_level == r_stable) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_stable <= w_level;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_done & w_level & ~r_stable;
endmodule

// File: rtl/board_input_port.sv
// rtl/board_input_port.sv - debounced KEY/SW register slave with sticky press events and irq
module board_input_port
    import board_input_port_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] i_key_raw,
    input  logic [N_SW-1:0]   i_sw_raw,
    board_input_port_if.slave bus
);
    logic [N_KEYS-1:0]     w_key_stable;
    logic [N_KEYS-1:0]     w_key_rise;
    logic [N_SW-1:0]       w_sw_stable;
    logic [N_SW-1:0]       w_sw_rise_unused;
    logic [N_KEYS-1:0]     r_events;
    logic [N_KEYS-1:0]     r_irq_en;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_irq;
    reg_sel_e              w_sel;
    logic                  w_rd;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_rd_mux;
    logic [N_KEYS-1:0]     w_ev_clr;
    logic                  w_bus_unused;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b1)) u_deb (
            .clk(clk), .rst(rst), .i_raw(i_key_raw[g]),
            .o_stable(w_key_stable[g]), .o_rise(w_key_rise[g])
        );
    end

    for (genvar g = 0; g < N_SW; g++) begin : g_sw
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b0)) u_deb (
            .clk(clk), .rst(rst), .i_raw(i_sw_raw[g]),
            .o_stable(w_sw_stable[g]), .o_rise(w_sw_rise_unused[g])
        );
    end

    assign w_sel        = reg_sel_e'(bus.addr[REG_SEL_LSB+1:REG_SEL_LSB]);
    assign w_rd         = bus.rd_en;
    assign w_wr         = bus.wr_en & ~bus.rd_en;
    assign w_bus_unused = ^{bus.addr[ADDR_WIDTH-1:REG_SEL_LSB+2], bus.addr[REG_SEL_LSB-1:0],
                            bus.wr_data[DATA_WIDTH-1:N_KEYS]};

    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            REG_KEYS:   w_rd_mux = DATA_WIDTH'(w_key_stable);
            REG_SW:     w_rd_mux = DATA_WIDTH'(w_sw_stable);
            REG_EVENTS: w_rd_mux = DATA_WIDTH'(r_events);
            REG_IRQ_EN: w_rd_mux = DATA_WIDTH'(r_irq_en);
            default:    w_rd_mux = '0;
        endcase
    end

    // A read clears exactly the bits it returns; new presses are OR-ed in after the clear
    always_comb begin
        w_ev_clr = '0;
        if (w_rd && w_sel == REG_EVENTS) w_ev_clr = w_ev_clr | r_events;
        if (w_wr && w_sel == REG_EVENTS) w_ev_clr = w_ev_clr | bus.wr_data[N_KEYS-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_events   <= '0;
            r_irq_en   <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) r_rd_data <= w_rd_mux;
            r_events <= (r_events & ~w_ev_clr) | w_key_rise;
            if (w_wr && w_sel == REG_IRQ_EN) r_irq_en <= bus.wr_data[N_KEYS-1:0];
            r_irq <= |(r_events & r_irq_en);
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.irq      = r_irq;
endmodule

// File: tb/tb_board_input_port.sv
// tb/tb_board_input_port.sv - directed self-checking bench for board_input_port
module tb_board_input_port;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_raw;
    logic [9:0] sw_raw;
    int         n_checks = 0;
    int         n_errors = 0;

    board_input_port_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    board_input_port #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .N_KEYS(4), .N_SW(10), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .i_key_raw(key_raw), .i_sw_raw(sw_raw), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input string tag, input logic [1:0] reg_idx, input logic [31:0] exp);
        bus.addr  = {28'h0, reg_idx, 2'b00};
        bus.rd_en = 1'b1;
        tick();
        chk({tag, "_valid"}, {31'h0, bus.rd_valid}, 32'h1);
        chk(tag, bus.rd_data, exp);
        bus.rd_en = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] reg_idx, input logic [31:0] data);
        bus.addr    = {28'h0, reg_idx, 2'b00};
        bus.wr_data = data;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; key_raw = 4'hF; sw_raw = 10'h0;
        bus.addr = '0; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0;

        tick(3);
        chk("rst_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_irq", {31'h0, bus.irq}, 32'h0);
        rst = 1'b1;
        tick(2);

        bus_read("init_keys", 2'd0, 32'h0);
        bus_read("init_sw", 2'd1, 32'h0);
        bus_read("init_events", 2'd2, 32'h0);
        bus_read("init_irq_en", 2'd3, 32'h0);
        tick();
        chk("rd_valid_one_cycle", {31'h0, bus.rd_valid}, 32'h0);
        chk("init_irq", {31'h0, bus.irq}, 32'h0);

        // key1 pressed for 10 cycles: accepted on the 6th edge
        key_raw = 4'hD;
        tick(5);
        bus_read("key1_edge6", 2'd0, 32'h0);
        bus_read("key1_edge7", 2'd0, 32'h2);
        bus_read("key1_events", 2'd2, 32'h2);
        bus_read("key1_events_cleared", 2'd2, 32'h0);
        tick();
        key_raw = 4'hF;
        tick(8);
        bus_read("key1_released", 2'd0, 32'h0);
        bus_read("key1_release_no_event", 2'd2, 32'h0);

        // three-cycle glitch on key0 is rejected
        key_raw = 4'hE;
        tick(3);
        key_raw = 4'hF;
        tick(8);
        bus_read("glitch_keys", 2'd0, 32'h0);
        bus_read("glitch_events", 2'd2, 32'h0);

        bus_write(2'd3, 32'h1);
        bus_read("irq_en_set", 2'd3, 32'h1);
        bus.addr = 32'hC; bus.wr_data = 32'hF; bus.rd_en = 1'b1; bus.wr_en = 1'b1;
        tick();
        chk("rd_wr_collide_data", bus.rd_data, 32'h1);
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        bus_read("wr_ignored_on_rd", 2'd3, 32'h1);

        key_raw = 4'hE;
        tick(6);
        chk("irq_lags_event", {31'h0, bus.irq}, 32'h0);
        tick();
        chk("irq_on_key0", {31'h0, bus.irq}, 32'h1);
        bus_write(2'd2, 32'h1);
        chk("irq_after_w1c_edge", {31'h0, bus.irq}, 32'h1);
        tick();
        chk("irq_cleared_w1c", {31'h0, bus.irq}, 32'h0);
        key_raw = 4'hF;
        tick(8);
        bus_read("key0_release_no_event", 2'd2, 32'h0);

        // EVENTS read lands on the same edge the key2 press is accepted
        key_raw = 4'hB;
        tick(5);
        bus.addr = 32'h8; bus.rd_en = 1'b1;
        tick();
        chk("collide_rd_valid", {31'h0, bus.rd_valid}, 32'h1);
        bus.rd_en = 1'b0;
        bus_read("collide_event_kept", 2'd2, 32'h4);
        bus_read("collide_event_cleared", 2'd2, 32'h0);
        chk("irq_masked_key2", {31'h0, bus.irq}, 32'h0);
        key_raw = 4'hF;
        tick(8);

        sw_raw = 10'h3FF;
        tick(5);
        bus_read("sw_edge6", 2'd1, 32'h0);
        bus_read("sw_edge7", 2'd1, 32'h3FF);

        // reset mid-count and mid-read, with key3 held through reset
        sw_raw = 10'h155; key_raw = 4'h7;
        tick(3);
        bus.addr = 32'h4; bus.rd_en = 1'b1; rst = 1'b0;
        tick();
        chk("rst_mid_read_valid", {31'h0, bus.rd_valid}, 32'h0);
        chk("rst_mid_read_data", bus.rd_data, 32'h0);
        chk("rst_mid_irq", {31'h0, bus.irq}, 32'h0);
        bus.rd_en = 1'b0; rst = 1'b1;
        tick(5);
        bus_read("sw_restart_edge6", 2'd1, 32'h0);
        bus_read("sw_restart_edge7", 2'd1, 32'h155);
        bus_read("held_key_event", 2'd2, 32'h8);
        bus_read("held_key_level", 2'd0, 32'h8);
        bus_read("irq_en_after_rst", 2'd3, 32'h0);
        tick();
        chk("irq_after_rst", {31'h0, bus.irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
